// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logicUnit between two requesters over valid/ready.
// Optional feature: define LU_ARB_ERR_EN to flag non-one-hot opcodes via rsp_err.
module logic_unit_arbiter #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,
  output logic [2:0]    lu_opCode,
  output logic [DW-1:0] lu_A,
  output logic [DW-1:0] lu_B,
  input  logic [DW-1:0] lu_resultA,
  input  logic [DW-1:0] lu_resultO,
  input  logic [DW-1:0] lu_resultX,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [2:0]    lu_op_q, lu_op_d;
  logic [DW-1:0] lu_a_q, lu_a_d;
  logic [DW-1:0] lu_b_q, lu_b_d;
  logic          err_q, err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          grant0, grant1;
  logic [2:0]    acc_op, acc_op_eff;
  logic          acc_err;
  logic [DW-1:0] sel_result;

  // On a tie the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign acc_op = grant1 ? req1_op : req0_op;

`ifdef LU_ARB_ERR_EN
  always_comb begin
    acc_err    = !((acc_op == 3'b001) || (acc_op == 3'b010) || (acc_op == 3'b100));
    acc_op_eff = acc_err ? 3'b000 : acc_op;
  end
`else
  // Multi-bit opcodes collapse to their lowest set bit.
  always_comb begin
    acc_err = 1'b0;
    if (acc_op[0]) begin
      acc_op_eff = 3'b001;
    end else if (acc_op[1]) begin
      acc_op_eff = 3'b010;
    end else if (acc_op[2]) begin
      acc_op_eff = 3'b100;
    end else begin
      acc_op_eff = 3'b000;
    end
  end
`endif

  always_comb begin
    unique case (lu_op_q)
      3'b001:  sel_result = lu_resultA;
      3'b010:  sel_result = lu_resultO;
      3'b100:  sel_result = lu_resultX;
      default: sel_result = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lu_op_d      = 3'b000;
    lu_a_d       = '0;
    lu_b_d       = '0;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          state_d      = StExec;
          last_grant_d = grant1;
          lu_op_d      = acc_op_eff;
          lu_a_d       = grant1 ? req1_a : req0_a;
          lu_b_d       = grant1 ? req1_b : req0_b;
          err_d        = acc_err;
          rsp_id_d     = grant1;
        end
      end
      StExec: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_data_d  = sel_result;
        rsp_err_d   = err_q;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      lu_op_q      <= 3'b000;
      lu_a_q       <= '0;
      lu_b_q       <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lu_op_q      <= lu_op_d;
      lu_a_q       <= lu_a_d;
      lu_b_q       <= lu_b_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign lu_opCode  = lu_op_q;
  assign lu_A       = lu_a_q;
  assign lu_B       = lu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule
